// File: rtl/pc_seq_pkg.sv
// Default configuration shared by the PC sequencer and its return-address stack.
package pc_seq_pkg;
    localparam int unsigned PC_WIDTH_DEF  = 30;
    localparam int unsigned RESET_VEC_DEF = 0;
    localparam int unsigned EXC_VEC_DEF   = 1;
    localparam int unsigned RAS_DEPTH_DEF = 4;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushes past capacity overwrite the oldest entry.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH_DEF,
    parameter int unsigned DEPTH = RAS_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, top_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             wr_en;

    // ptr_q is the next free slot; the top sits one below it
    assign top_idx = ptr_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign empty   = empty_q;
    assign full    = full_q;
    assign wr_en   = push && !flush;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (flush) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
        end else if (pop && cnt_q != '0) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CW'(1);
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // Entry contents carry no reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (!reset && wr_en) mem_q[ptr_q] <= push_data;
    end
endmodule

// File: rtl/pc_seq.sv
// Fetch PC sequencer: reset/exception/stall/redirect/return/increment priority
// with a one-deep pending redirect captured across stalls.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH     = PC_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
    parameter int unsigned      RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exc,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_valid,
    output logic             ras_empty,
    output logic             ras_full
);
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic             vld_q, vld_d;
    logic             pend_q, pend_d;
    logic             pend_call_q, pend_call_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             ras_push, ras_pop, ras_flush;
    logic [WIDTH-1:0] ras_top;

    assign pc_inc   = pc_q + WIDTH'(1);
    assign pc_out   = pc_q;
    assign pc_valid = vld_q;

    pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (ras_flush),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_comb begin
        pc_d        = pc_inc;
        vld_d       = 1'b1;
        pend_d      = pend_q;
        pend_call_d = pend_call_q;
        pend_tgt_d  = pend_tgt_q;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_flush   = 1'b0;
        if (exc) begin
            pc_d      = EXC_VEC;
            pend_d    = 1'b0;
            ras_flush = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
            // Latest redirect seen during the stall wins; ret is dropped
            if (redirect_valid) begin
                pend_d      = 1'b1;
                pend_call_d = call;
                pend_tgt_d  = redirect_target;
            end
        end else if (pend_q) begin
            pc_d     = pend_tgt_q;
            pend_d   = 1'b0;
            ras_push = pend_call_q;
        end else if (redirect_valid) begin
            pc_d     = redirect_target;
            ras_push = call;
        end else if (ret && !ras_empty) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VEC;
            vld_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_call_q <= 1'b0;
            pend_tgt_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            vld_q       <= vld_d;
            pend_q      <= pend_d;
            pend_call_q <= pend_call_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end
endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL: parameter WIDTH, default 30, PC width in words (word-addressed).
REQ-002 SHALL: parameter RESET_VEC, default 0, PC value loaded by reset.
REQ-003 SHALL: parameter EXC_VEC, default 1, PC value loaded on exception.
REQ-004 SHALL: parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL: stall  input  1  hold PC this edge.
REQ-008 SHALL: redirect_valid  input  1  branch/jump taken this cycle.
REQ-009 SHALL: redirect_target  input  WIDTH  branch/jump destination.
REQ-010 SHALL: call  input  1  qualifies redirect_valid as a call (push return address).
REQ-011 SHALL: ret  input  1  return: next PC from RAS top.
REQ-012 SHALL: exc  input  1  exception request.
REQ-013 SHALL: pc_out  output  WIDTH  current fetch PC (registered).
REQ-014 SHALL: pc_valid  output  1  pc_out is a live fetch address.
REQ-015 SHALL: ras_empty / ras_full  output  1 each  RAS occupancy flags (registered).

Function
REQ-016 SHALL: next-PC priority per edge: reset > exc > stall > pending redirect > redirect_valid > ret (RAS non-empty) > increment.
REQ-017 SHALL: increment is pc_out+1 modulo 2^WIDTH; all-ones wraps to 0, no flag.
REQ-018 SHALL: redirect_valid without stall loads redirect_target at the next edge (1-cycle latency).
REQ-019 SHALL: redirect_valid with call pushes pc_out+1 (mod 2^WIDTH) onto RAS on the same edge the target is loaded.
REQ-020 SHALL: ret with RAS non-empty and redirect_valid low loads RAS top and pops on the next edge.
REQ-021 SHALL: ret with RAS empty behaves as plain increment; RAS unchanged.
REQ-022 SHALL: ret is ignored when redirect_valid is high the same cycle.
REQ-023 SHALL: push when full overwrites the oldest entry (circular); ras_full stays 1, occupancy stays RAS_DEPTH.
REQ-024 SHALL: stall holds pc_out and RAS; redirect_valid (with call) during stall is captured in a pending register; a later redirect during the same stall overwrites it.
REQ-025 SHALL: on the first non-stalled edge a pending redirect applies (target load, push if call) and clears; live inputs that cycle are ignored.
REQ-026 SHALL: ret during stall is dropped (not captured).
REQ-027 SHALL: exc, even during stall, loads EXC_VEC, flushes RAS to empty, clears pending.
REQ-028 SHALL: pc_valid is 0 while reset is high and 1 from the first edge with reset low; stall does not drop pc_valid.

Reset
REQ-029 SHALL: reset high at an edge sets pc_out=RESET_VEC, pc_valid=0, ras_empty=1, ras_full=0, pending cleared, RAS pointer 0.
REQ-030 SHALL: reset mid-stall or with pending redirect discards all state; all other inputs ignored that edge.
REQ-031 SHALL: RAS entry contents need not be reset; only pointer/count are.

Structure
REQ-032 SHALL: shared package holds default WIDTH, RESET_VEC, EXC_VEC, RAS_DEPTH constants only.
REQ-033 SHALL: RAS is one sub-module, pc_ras (push, pop, flush, top, empty, full; circular pointer plus count).
REQ-034 SHALL: pc_seq holds pc register, pending register, priority mux; no latches, no combinational path input->pc_out.

Verification
REQ-035 SHALL: reset 1 cycle, then 4 idle edges -> pc_out 0,1,2,3,4; pc_valid 0 in reset, 1 after.
REQ-036 SHALL: pc_out=0x3FFFFFFF, idle edge -> pc_out=0.
REQ-037 SHALL: at pc 5, redirect_valid+call target 0x40 -> pc 0x40, RAS top 6; later ret -> pc 6, ras_empty=1.
REQ-038 SHALL: stall 3 cycles with redirect target 0x20 in cycle 1 and 0x30 in cycle 2 -> pc held, then 0x30 on release.
REQ-039 SHALL: RAS_DEPTH=4, 5 calls from pcs 1..5 -> ras_full=1; 4 rets yield 6,5,4,3; 5th ret increments.
REQ-040 SHALL: exc during stall with pending redirect and 2 RAS entries -> pc=EXC_VEC, ras_empty=1, no pending applied after stall.
